// File: rtl/key_event_queue.sv
// key_event_queue: FIFO of keyboard scan codes captured on scan_code_ready rising edges, drained over valid/ready
//   clk, reset        clock and asynchronous active-high reset
//   scan_code         code from the keyboard stage; scan_code_ready rising edge announces it
//   input_done        queue not full, fed back to the keyboard stage
//   key_data          head-of-queue code, qualified by key_valid; key_ready pops it
//   count             entries held, 0..DEPTH
//   overflow          sticky drop flag, cleared by clear_overflow (a drop in the same cycle wins)
module key_event_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        scan_code,
    input  logic              scan_code_ready,
    output logic              input_done,
    output logic [7:0]        key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clear_overflow
);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              rdy_q, push_req, pop, push, full;
    assign full       = count == (ADDR_W+1)'(DEPTH);
    assign key_valid  = count != '0;
    assign input_done = !full;
    assign key_data   = mem[rd_ptr];
    assign push_req   = scan_code_ready && !rdy_q && scan_code != 8'h00;
    assign pop        = key_valid && key_ready;
    // a full queue still takes a code when the head leaves in the same cycle
    assign push       = push_req && (!full || pop);
    // rdy_q resets high so a level held through reset is not seen as a new event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rdy_q    <= scan_code_ready;
            wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count    <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            overflow <= (push_req && !push) || (overflow && !clear_overflow);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= scan_code;
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: scoreboard bench for key_event_queue
module tb_key_event_queue;
    logic       clk = 0, reset = 1;
    logic [7:0] scan_code = 0;
    logic       scan_code_ready = 0, key_ready = 0, clear_overflow = 0;
    logic       input_done, key_valid, overflow;
    logic [7:0] key_data;
    logic [3:0] count;
    logic [7:0] q[$];
    logic       exp_ovf = 0;
    int         vectors = 0, miscompares = 0;

    key_event_queue dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_code_ready(scan_code_ready),
        .input_done(input_done), .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .count(count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".valid"}, 32'(key_valid), 32'(q.size() != 0));
        check({tag, ".done"}, 32'(input_done), 32'(q.size() != 8));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic push_code(input logic [7:0] c);
        scan_code = c;
        scan_code_ready = 1;
        step();
        scan_code_ready = 0;
        if (c != 0) begin
            if (q.size() < 8) q.push_back(c);
            else exp_ovf = 1;
        end
        step();
    endtask

    task automatic pop_one();
        logic [7:0] e;
        check("pop.valid", 32'(key_valid), 1);
        e = q.pop_front();
        check("pop.data", 32'(key_data), 32'(e));
        key_ready = 1;
        step();
        key_ready = 0;
    endtask

    // push c and pop the head in the same edge; the head must be present beforehand
    task automatic push_pop(input logic [7:0] c);
        check("pp.data", 32'(key_data), 32'(q[0]));
        scan_code = c;
        scan_code_ready = 1;
        key_ready = 1;
        step();
        scan_code_ready = 0;
        key_ready = 0;
        void'(q.pop_front());
        q.push_back(c);
        check("pp.count", 32'(count), 32'(q.size()));
        check("pp.ovf", 32'(overflow), 32'(exp_ovf));
        step();
    endtask

    initial begin
        step();
        step();
        check_state("reset");
        reset = 0;
        step();

        scan_code = 8'h41;
        scan_code_ready = 1;
        step();
        check("lat.count", 32'(count), 1);
        check("lat.valid", 32'(key_valid), 1);
        check("lat.data", 32'(key_data), 32'h41);
        scan_code_ready = 0;
        q.push_back(8'h41);
        step();
        pop_one();
        check_state("pop1");

        scan_code = 8'h22;
        scan_code_ready = 1;
        for (int i = 0; i < 10; i++) step();
        scan_code_ready = 0;
        step();
        q.push_back(8'h22);
        check_state("hold");
        pop_one();

        push_code(8'h00);
        check_state("zero");

        for (int i = 1; i <= 8; i++) push_code(8'(i));
        check_state("full");
        push_code(8'h09);
        check_state("drop");
        clear_overflow = 1;
        step();
        clear_overflow = 0;
        exp_ovf = 0;
        check_state("clr");
        scan_code = 8'h0A;
        scan_code_ready = 1;
        clear_overflow = 1;
        step();
        scan_code_ready = 0;
        clear_overflow = 0;
        exp_ovf = 1;
        step();
        check_state("setwins");
        clear_overflow = 1;
        step();
        clear_overflow = 0;
        exp_ovf = 0;
        for (int i = 0; i < 8; i++) begin
            pop_one();
            check_state("drain");
        end

        scan_code = 8'h77;
        scan_code_ready = 1;
        key_ready = 1;
        step();
        check("empty_pp.count", 32'(count), 1);
        check("empty_pp.data", 32'(key_data), 32'h77);
        scan_code_ready = 0;
        key_ready = 0;
        q.push_back(8'h77);
        step();
        pop_one();

        for (int i = 1; i <= 8; i++) push_code(8'(8'h10 + i));
        push_pop(8'h55);
        check_state("fullpp");
        for (int i = 0; i < 8; i++) pop_one();
        check_state("fullpp.drain");

        for (int i = 0; i < 3; i++) push_code(8'(8'h30 + i));
        for (int i = 0; i < 20; i++) push_pop(8'(8'h60 + i));
        while (q.size() != 0) pop_one();
        check_state("wrap");

        for (int i = 0; i < 5; i++) push_code(8'(8'hA0 + i));
        check("pre_rst.count", 32'(count), 5);
        scan_code = 8'h99;
        scan_code_ready = 1;
        reset = 1;
        #1;
        q.delete();
        exp_ovf = 0;
        check_state("midrst");
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) step();
        check_state("post_rst");
        scan_code_ready = 0;
        step();
        check_state("post_rst.low");
        scan_code_ready = 1;
        step();
        scan_code_ready = 0;
        q.push_back(8'h99);
        check_state("post_rst.rise");
        pop_one();
        check_state("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Downstream consumer of the switch-keyboard stage. Captures each new `scan_code` announced by a rising edge of `scan_code_ready` into a small FIFO and presents codes to game/control logic over a valid/ready handshake. Drives `input_done` back to the keyboard stage so it only latches new switch values while there is room. Reports occupancy and a sticky overflow flag.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `ADDR_W`, 3, log2(`DEPTH`).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `scan_code`  in  8  code from the keyboard stage.
- `scan_code_ready`  in  1  level from the keyboard stage; a rising edge announces a new code.
- `input_done`  out  1  high when the queue can accept a code (not full); fed to the keyboard stage's `inputDone`.
- `key_data`  out  8  head-of-queue code; valid only while `key_valid` is high.
- `key_valid`  out  1  queue non-empty.
- `key_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  `ADDR_W+1`  entries currently held, 0..`DEPTH`.
- `overflow`  out  1  sticky; set when a code is dropped.
- `clear_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Edge detect:
  - Register `rdy_q` samples `scan_code_ready` every cycle.
  - `rise = scan_code_ready & ~rdy_q`.
  - `rdy_q` resets to 1, so a level held high through reset is not a new event.
- Push request: `rise && scan_code != 8'h00`. A zero code is ignored: no push, no overflow.
- Pop: `key_valid && key_ready`. A pop while empty is ignored, with no pointer or count change.
- Push acceptance: a push is accepted if `count < DEPTH`, or if a pop occurs in the same cycle.
- Push rejection: a push request that is not accepted drops the code and sets `overflow`.
- Memory is `DEPTH` x 8.
  - Write at `wr_ptr`, read at `rd_ptr`.
  - Both pointers are `ADDR_W` bits and wrap modulo `DEPTH` (7 -> 0 for the default).
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Show-ahead read: `key_data = mem[rd_ptr]` combinationally from registered state. `key_valid = (count != 0)`.
- `input_done = (count != DEPTH)`.
- `overflow`:
  - Set on a dropped push.
  - Cleared by `clear_overflow`.
  - If both happen in the same cycle, set wins.
- Reset, asynchronous and allowed mid-operation:
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `overflow` = 0.
  - `rdy_q` = 1.
  - Memory contents are not reset.

## Timing
- Reset values:
  - `key_valid` = 0
  - `count` = 0
  - `overflow` = 0
  - `input_done` = 1
  - `key_data` = don't-care; `mem` is not reset.
- Push latency:
  - `scan_code_ready` rises before clock edge N; the code is written at edge N.
  - After edge N: `key_valid` = 1 (if previously empty), `count` incremented, `key_data` = code.
- Pop:
  - Handshake completes at the edge where `key_valid && key_ready`.
  - The next entry appears on `key_data` after that edge.
  - Back-to-back pops, one per cycle, are supported.
- `scan_code_ready` held high for many cycles produces exactly one push. It must return low for at least one sampled cycle before the next event counts.
- Full:
  - `input_done` goes low the cycle after the push that fills the queue.
  - It returns high the cycle after the first pop.
- Full with simultaneous push and pop: push accepted, `count` stays `DEPTH`, no overflow.
- Empty with simultaneous push and pop request: the pop is ignored (`key_valid` = 0) and the push is accepted. `key_valid` goes high next cycle.
- Throughput: at most one push and one pop per cycle.

## Test plan
- Reset, then pulse `scan_code_ready` for 1 cycle with `scan_code` = 0x41 -> next cycle `key_valid` = 1, `key_data` = 0x41, `count` = 1. Assert `key_ready` for one cycle -> `count` = 0, `key_valid` = 0.
- Hold `scan_code_ready` high for 10 cycles with `scan_code` = 0x22 -> exactly one entry, `count` = 1.
- Pulse `scan_code_ready` with `scan_code` = 0x00 -> `count` stays 0, `overflow` stays 0.
- Push 0x01..0x08 with `key_ready` = 0 -> `count` = 8, `input_done` = 0. Push 0x09 -> dropped, `overflow` = 1. Pop all 8 -> outputs 0x01..0x08 in order.
- Fill to 8, then in the same cycle push 0x55 and pop -> `count` stays 8, no overflow, 0x55 is the last entry out. Run 20 push/pop cycles to exercise pointer wrap with FIFO order preserved.
- Reset mid-stream with `count` = 5 and `scan_code_ready` held high -> `count` = 0, `key_valid` = 0, `overflow` = 0, `input_done` = 1. No push after reset deasserts until `scan_code_ready` falls and rises again.
